// File: rtl/sample_product_queue.sv
// Purpose: multiplies operand pairs with a shift-add multiplier and queues the products in a FWFT buffer.
// Latency: handshake at edge k, push at edge k+WIDTH+1; peak throughput one sample per WIDTH+2 cycles.
// Backpressure: in_ready is low from the handshake until the product is pushed; a full queue stalls the push.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake carrying param0 (multiplicand) and param1 (multiplier)
//   pop                   consumer removes the head entry (ignored while empty)
//   out_valid/out_data    head-of-queue product, first-word-fall-through
//   full/empty/level      queue occupancy status
//   sample_count          products pushed since reset, saturating
module sample_product_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           param0,
  input  logic [WIDTH-1:0]           param1,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [2*WIDTH-1:0]         out_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           sample_count
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MULT, PUSH} state_t;

  state_t           state;
  logic [PW-1:0]    mcand;    // multiplicand, pre-shifted by the current bit index
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [BW-1:0]    bit_cnt;

  logic [PW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic push_ok;
  logic pop_ok;

  // A full queue still accepts a push when the head leaves at the same edge.
  assign push_ok   = (state == PUSH) && (!full || pop);
  assign pop_ok    = pop && !empty;

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // Multiplier FSM. in_ready is registered so it is low throughout reset
  // and comes up one cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mcand    <= {{WIDTH{1'b0}}, param0};
            mplier   <= param1;
            acc      <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= MULT;
          end
        end
        MULT: begin
          // Fixed WIDTH iterations, no early exit, so latency never varies.
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) begin
            state <= PUSH;
          end
        end
        PUSH: begin
          if (push_ok) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Circular buffer; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= acc;
        wr_ptr      <= wr_ptr + PTR_ONE;
        if (sample_count != '1) begin
          sample_count <= sample_count + CNT_ONE;
        end
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule
